control_unit: RTL and testbench



---
 rtl/risc_pkg.sv | 37 +++
 rtl/control_unit_if.sv | 24 ++
 rtl/control_unit_alu_decoder.sv | 32 +++
 rtl/control_unit.sv | 77 +++++++
 tb/tb_control_unit.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
// Shared ISA definitions for the 16-bit RISC core: opcodes, ALU operation codes and the decoded control bundle.
// Used by the control unit and the ALU.
package risc_pkg;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_ANDI  = 4'd2;
  localparam logic [3:0] OP_LW    = 4'd3;
  localparam logic [3:0] OP_SW    = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LI    = 4'd6;
  localparam logic [3:0] OP_BEQ   = 4'd7;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_NOR   = 4'd5;
  localparam logic [3:0] ALU_SLL   = 4'd6;
  localparam logic [3:0] ALU_SRL   = 4'd7;
  localparam logic [3:0] ALU_SRA   = 4'd8;
  localparam logic [3:0] ALU_SLT   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic [3:0] alu_control;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       alu_src;
    logic       reg_data;
    logic       const_src;
  } ctrl_t;

endpackage

// File: rtl/control_unit_if.sv
// Instruction-field inputs and registered datapath controls of the main decoder.
// master = fetch/decode side driving fields, slave = the control unit.
interface control_unit_if;
  logic [3:0] opcode;
  logic [3:0] FnCode;
  logic [3:0] alu_control;
  logic       Branch;
  logic       regWrite;
  logic       MemWrite;
  logic       MemRead;
  logic       ALU_src;
  logic       reg_data;
  logic       const_src;

  modport master (
    output opcode, FnCode,
    input  alu_control, Branch, regWrite, MemWrite, MemRead, ALU_src, reg_data, const_src
  );

  modport slave (
    input  opcode, FnCode,
    output alu_control, Branch, regWrite, MemWrite, MemRead, ALU_src, reg_data, const_src
  );
endinterface

// File: rtl/control_unit_alu_decoder.sv
// Combinational ALU operation select from (opcode, FnCode); flags R-type function codes
// outside the implemented range so the main decoder can turn them into a NOP.
module alu_decoder
  import risc_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] fn_code,
  output logic [3:0] alu_control,
  output logic       illegal_fn
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal_fn  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (fn_code > ALU_PASSB) begin
          illegal_fn = 1'b1;
        end else begin
          alu_control = fn_code;
        end
      end
      OP_ANDI: alu_control = ALU_AND;
      OP_ORI:  alu_control = ALU_OR;
      OP_LI:   alu_control = ALU_PASSB;
      OP_BEQ:  alu_control = ALU_SUB;
      // ADDI, LW, SW and unimplemented opcodes all use ADD
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Main decoder: opcode/FnCode to registered ALU, register-file, memory and operand-mux controls.
// One cycle latency, one instruction per cycle; async active-high reset clears every output.
module control_unit
  import risc_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  control_unit_if.slave  bus
);

  logic [3:0] alu_code;
  logic       illegal_fn;
  ctrl_t      ctrl_d;
  ctrl_t      ctrl_q;

  alu_decoder u_alu_decoder (
    .opcode      (bus.opcode),
    .fn_code     (bus.FnCode),
    .alu_control (alu_code),
    .illegal_fn  (illegal_fn)
  );

  always_comb begin
    ctrl_d             = '0;
    ctrl_d.alu_control = alu_code;
    case (bus.opcode)
      OP_RTYPE: begin
        if (illegal_fn) begin
          ctrl_d = '0;
        end else begin
          ctrl_d.reg_write = 1'b1;
        end
      end
      OP_ADDI: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_LI: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.const_src = 1'b1;
        ctrl_d.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.reg_data  = 1'b1;
        ctrl_d.reg_write = 1'b1;
      end
      OP_SW: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl_d.branch = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign bus.alu_control = ctrl_q.alu_control;
  assign bus.Branch      = ctrl_q.branch;
  assign bus.regWrite    = ctrl_q.reg_write;
  assign bus.MemWrite    = ctrl_q.mem_write;
  assign bus.MemRead     = ctrl_q.mem_read;
  assign bus.ALU_src     = ctrl_q.alu_src;
  assign bus.reg_data    = ctrl_q.reg_data;
  assign bus.const_src   = ctrl_q.const_src;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus randomized back-to-back decode
// compared against a table-driven reference model one cycle behind the inputs.
module tb_control_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  control_unit_if bus ();

  control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {alu[3:0], Branch, regWrite, MemWrite, MemRead, ALU_src, reg_data, const_src}
  function automatic logic [10:0] observed();
    return {bus.alu_control, bus.Branch, bus.regWrite, bus.MemWrite, bus.MemRead,
            bus.ALU_src, bus.reg_data, bus.const_src};
  endfunction

  // Reference: per-opcode table of {alu, Branch, regWrite, MemWrite, MemRead, ALU_src, reg_data, const_src}
  function automatic logic [10:0] model(input logic [3:0] op, input logic [3:0] fn);
    logic [10:0] table_q [8];
    table_q[0] = 11'b0;
    table_q[1] = {4'd0,  7'b0100100};
    table_q[2] = {4'd2,  7'b0100101};
    table_q[3] = {4'd0,  7'b0101110};
    table_q[4] = {4'd0,  7'b0010100};
    table_q[5] = {4'd3,  7'b0100101};
    table_q[6] = {4'd10, 7'b0100101};
    table_q[7] = {4'd1,  7'b1000000};
    if (op >= 4'd8) return 11'b0;
    if (op == 4'd0) return (fn <= 4'd10) ? {fn, 7'b0100000} : 11'b0;
    return table_q[op[2:0]];
  endfunction

  // Drive fields just after an edge, then sample 1 time unit after the capturing edge
  task automatic step(input logic [3:0] op, input logic [3:0] fn);
    bus.opcode = op;
    bus.FnCode = fn;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.opcode = 4'd0;
    bus.FnCode = 4'd0;
    #12;
    rst = 1'b0;
    step(4'd3, 4'd0);
    checks++;
    if (observed() !== model(4'd3, 4'd0)) begin
      errors++;
      $display("FAIL reset_preload got=%b want=%b", observed(), model(4'd3, 4'd0));
    end
    bus.opcode = 4'd0;
    bus.FnCode = 4'd0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (observed() !== 11'b0) begin
      errors++;
      $display("FAIL reset_async_clear got=%b want=%b", observed(), 11'b0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (observed() !== 11'b0) begin
      errors++;
      $display("FAIL reset_held got=%b want=%b", observed(), 11'b0);
    end
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.alu_control !== 4'd0 || bus.regWrite !== 1'b1) begin
      errors++;
      $display("FAIL reset_release alu=%0d regWrite=%b want alu=0 regWrite=1", bus.alu_control, bus.regWrite);
    end
  endtask

  task automatic test_rtype_sweep();
    for (int f = 0; f < 16; f++) begin
      step(4'd0, 4'(f));
      checks++;
      if (f <= 10) begin
        if (bus.alu_control !== 4'(f) || bus.regWrite !== 1'b1 || observed() !== model(4'd0, 4'(f))) begin
          errors++;
          $display("FAIL rtype_fn%0d got=%b want alu=%0d regWrite=1", f, observed(), f);
        end
      end else if (observed() !== 11'b0) begin
        errors++;
        $display("FAIL rtype_illegal_fn%0d got=%b want=%b", f, observed(), 11'b0);
      end
    end
  endtask

  task automatic test_lw_sw();
    step(4'd3, 4'($urandom_range(15)));
    checks++;
    if (observed() !== {4'd0, 7'b0101110}) begin
      errors++;
      $display("FAIL lw got=%b want=%b", observed(), {4'd0, 7'b0101110});
    end
    step(4'd4, 4'($urandom_range(15)));
    checks++;
    if (observed() !== {4'd0, 7'b0010100}) begin
      errors++;
      $display("FAIL sw got=%b want=%b", observed(), {4'd0, 7'b0010100});
    end
  endtask

  task automatic test_beq_li();
    step(4'd7, 4'($urandom_range(15)));
    checks++;
    if (observed() !== {4'd1, 7'b1000000}) begin
      errors++;
      $display("FAIL beq got=%b want=%b", observed(), {4'd1, 7'b1000000});
    end
    step(4'd6, 4'($urandom_range(15)));
    checks++;
    if (observed() !== {4'd10, 7'b0100101}) begin
      errors++;
      $display("FAIL li got=%b want=%b", observed(), {4'd10, 7'b0100101});
    end
  endtask

  task automatic test_unused_opcodes();
    for (int op = 8; op < 16; op++) begin
      step(4'(op), 4'($urandom_range(15)));
      checks++;
      if (observed() !== 11'b0) begin
        errors++;
        $display("FAIL unused_op%0d got=%b want=%b", op, observed(), 11'b0);
      end
    end
  endtask

  task automatic test_back_to_back_random();
    logic [3:0]  op;
    logic [3:0]  fn;
    logic [10:0] obs;
    int          bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      op = 4'($urandom_range(15));
      fn = 4'($urandom_range(15));
      step(op, fn);
      obs = observed();
      checks++;
      if (obs !== model(op, fn)) begin
        errors++;
        bad++;
        if (bad <= 10) $display("FAIL random_decode op=%0d fn=%0d got=%b want=%b", op, fn, obs, model(op, fn));
      end
      checks++;
      if ((bus.MemRead && bus.MemWrite) || (bus.regWrite && (bus.Branch || bus.MemWrite)) ||
          (bus.reg_data && !bus.MemRead)) begin
        errors++;
        bad++;
        if (bad <= 10) $display("FAIL invariant op=%0d fn=%0d got=%b", op, fn, obs);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.opcode = 4'd0;
    bus.FnCode = 4'd0;
    test_reset();
    test_rtype_sweep();
    test_lw_sw();
    test_beq_li();
    test_unused_opcodes();
    test_back_to_back_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
